// File: rtl/brlite_mon_tx_pkg.sv
// brlite_mon_tx_pkg
// Shared types and constants for the BrLite monitor transmit path.
//   brlite_mon_t    : one monitor entry {payload, seq_source, producer, msvc}
//   mon_tx_state_e  : output handshake FSM states
//   make_seq_source : packs {sequence number, router address} into seq_source
package brlite_mon_tx_pkg;

  localparam int BRLITE_MON_NSVC       = 4;
  localparam int BRLITE_MON_SEQ_WIDTH  = 8;
  localparam int BRLITE_MON_ADDR_WIDTH = 8;
  localparam int BRLITE_MON_MSVC_WIDTH = $clog2(BRLITE_MON_NSVC);

  typedef logic [BRLITE_MON_SEQ_WIDTH-1:0]  mon_seq_t;
  typedef logic [BRLITE_MON_ADDR_WIDTH-1:0] mon_addr_t;
  typedef logic [BRLITE_MON_MSVC_WIDTH-1:0] mon_msvc_t;

  // Field order fixes the flit bit layout: payload occupies the MSBs.
  typedef struct packed {
    logic [31:0] payload;
    logic [15:0] seq_source;
    logic [15:0] producer;
    mon_msvc_t   msvc;
  } brlite_mon_t;

  typedef enum logic [1:0] {
    MON_TX_IDLE,
    MON_TX_SEND,
    MON_TX_RELEASE
  } mon_tx_state_e;

  function automatic logic [15:0] make_seq_source(input mon_seq_t seq, input mon_addr_t addr);
    return {seq, addr};
  endfunction

endpackage

// File: rtl/brlite_mon_tx_if.sv
// brlite_mon_tx_if
// Local monitor-sample channel between the PE/DMNI side and brlite_mon_tx.
//   mon_valid    : sample valid (source -> sink)
//   mon_ready    : sink can accept (sink -> source)
//   mon_msvc     : monitor service index
//   mon_producer : producer id
//   mon_payload  : sample value
// master = sample source, slave = brlite_mon_tx.
interface brlite_mon_tx_if;
  import brlite_mon_tx_pkg::*;

  logic        mon_valid;
  logic        mon_ready;
  mon_msvc_t   mon_msvc;
  logic [15:0] mon_producer;
  logic [31:0] mon_payload;

  modport master (
    output mon_valid, mon_msvc, mon_producer, mon_payload,
    input  mon_ready
  );

  modport slave (
    input  mon_valid, mon_msvc, mon_producer, mon_payload,
    output mon_ready
  );

endinterface

// File: rtl/brlite_mon_tx_fifo.sv
// brlite_mon_fifo
// Generic brlite_mon_t FIFO, DEPTH entries (power of two, >= 2).
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empties the FIFO; a coincident push is discarded
//   push       : write push_data at the tail
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (valid when !empty)
//   overwrite  : when set, a push into a full FIFO replaces the oldest entry
//   full/empty : occupancy flags, derived from registered count only
module brlite_mon_fifo
  import brlite_mon_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  brlite_mon_t push_data,
  input  logic        pop,
  output brlite_mon_t head,
  input  logic        overwrite,
  output logic        full,
  output logic        empty
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

  brlite_mon_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic do_pop;
  logic do_push;
  logic do_drop;
  logic rd_adv;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop || overwrite);
  // Overwrite: the head is sacrificed so the tail write has room.
  assign do_drop = push && full && overwrite && !do_pop;
  assign rd_adv  = do_pop || do_drop;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_adv)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(rd_adv);
    end
  end

  // Storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Head is read asynchronously so the FSM can capture it into its own
  // output register in the same cycle it pops.
  assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/brlite_mon_tx.sv
// brlite_mon_tx
// Transmit end of the BrLite monitor path: stamps local samples with a
// per-service 8-bit sequence number and the router address, queues them,
// and injects them one at a time over a 4-phase req/ack handshake.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : one-cycle pulse, flushes queue and sequence counters
//   mon           : sample channel (brlite_mon_tx_if.slave)
//   req_o, ack_i  : flit handshake toward the BrLite monitor router
//   flit_o        : outgoing entry, held stable while req_o is high
//   drop_cnt_o    : overwritten-sample count (0 unless drop mode)
// Build option: define BRLITE_MON_TX_DROP_EN to never backpressure; a push
// into a full queue overwrites the oldest entry and counts a drop.
module brlite_mon_tx
  import brlite_mon_tx_pkg::*;
#(
  parameter mon_addr_t ADDRESS     = 8'h00,
  parameter int        BUFFER_SIZE = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  brlite_mon_tx_if.slave     mon,
  output logic               req_o,
  input  logic               ack_i,
  output brlite_mon_t        flit_o,
  output logic [15:0]        drop_cnt_o
);

  mon_tx_state_e state_reg;
  mon_tx_state_e state_next;
  brlite_mon_t   flit_reg;
  mon_seq_t      seq_all [BRLITE_MON_NSVC];

  logic        mon_ready_int;
  logic        accept;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_overwrite;
  brlite_mon_t fifo_head;
  brlite_mon_t push_entry;

  assign mon.mon_ready = mon_ready_int;
  assign accept        = mon.mon_valid && mon_ready_int;
  // A sample accepted together with clear_i is discarded.
  assign fifo_push     = accept && !clear_i;

  // Per-service sequence counters. The counter still advances on an
  // accept that coincides with clear_i, but clear wins and zeroes it.
  for (genvar gi = 0; gi < BRLITE_MON_NSVC; gi++) begin : g_seq
    mon_seq_t cnt_reg;
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
        cnt_reg <= '0;
      end else if (accept && (mon.mon_msvc == BRLITE_MON_MSVC_WIDTH'(gi))) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign seq_all[gi] = cnt_reg;
  end

  always_comb begin
    push_entry            = '0;
    push_entry.payload    = mon.mon_payload;
    push_entry.seq_source = make_seq_source(seq_all[mon.mon_msvc], ADDRESS);
    push_entry.producer   = mon.mon_producer;
    push_entry.msvc       = mon.mon_msvc;
  end

  brlite_mon_fifo #(
    .DEPTH(BUFFER_SIZE)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (clear_i),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .overwrite(fifo_overwrite),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef BRLITE_MON_TX_DROP_EN
  logic [15:0] drop_cnt_reg;
  logic        drop_event;

  assign mon_ready_int  = 1'b1;
  assign fifo_overwrite = 1'b1;
  assign drop_event     = fifo_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      drop_cnt_reg <= '0;
    end else if (drop_event && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_reg;
`else
  // Ready depends only on registered occupancy, never on ack_i.
  assign mon_ready_int  = !fifo_full;
  assign fifo_overwrite = 1'b0;
  assign drop_cnt_o     = 16'h0000;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= MON_TX_IDLE;
      flit_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (fifo_pop) flit_reg <= fifo_head;
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      MON_TX_IDLE: begin
        // Do not launch an entry that clear_i is flushing this cycle.
        if (!fifo_empty && !clear_i) begin
          fifo_pop   = 1'b1;
          state_next = MON_TX_SEND;
        end
      end
      MON_TX_SEND: begin
        if (ack_i) state_next = MON_TX_RELEASE;
      end
      MON_TX_RELEASE: begin
        // Second half of the 4-phase handshake.
        if (!ack_i) state_next = MON_TX_IDLE;
      end
      default: state_next = MON_TX_IDLE;
    endcase
  end

  assign req_o  = (state_reg == MON_TX_SEND);
  assign flit_o = flit_reg;

endmodule

// File: tb/tb_brlite_mon_tx.sv
module tb_brlite_mon_tx;
  import brlite_mon_tx_pkg::*;

  localparam mon_addr_t ADDR  = 8'h21;
  localparam int        DEPTH = 4;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        clear_i = 1'b0;
  logic        ack_i   = 1'b0;
  logic        req_o;
  brlite_mon_t flit_o;
  logic [15:0] drop_cnt_o;

  brlite_mon_tx_if mon_if ();

  brlite_mon_tx #(
    .ADDRESS    (ADDR),
    .BUFFER_SIZE(DEPTH)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .mon       (mon_if),
    .req_o     (req_o),
    .ack_i     (ack_i),
    .flit_o    (flit_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad   = 0;
  int          flits_seen = 0;
  bit          ack_hold = 1'b1;
  brlite_mon_t exp_q[$];
  mon_seq_t    seq_model [BRLITE_MON_NSVC];

  // Router model: acks one cycle after seeing req, drops ack after req drops.
  initial begin
    forever begin
      @(negedge clk_i);
      if (ack_hold) ack_i = 1'b0;
      else          ack_i = req_o;
    end
  end

  // Scoreboard: every rising req_o must carry the next expected entry,
  // and flit_o must not change while req_o stays high.
  initial begin
    logic        prev_req;
    brlite_mon_t prev_flit;
    brlite_mon_t exp;
    prev_req  = 1'b0;
    prev_flit = '0;
    forever begin
      @(negedge clk_i);
      if (req_o === 1'b1 && !prev_req) begin
        flits_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL flit_unexpected got=%h want=none", flit_o);
        end else begin
          exp = exp_q.pop_front();
          if (flit_o !== exp) begin
            bad++;
            $display("FAIL flit_data got=%h want=%h", flit_o, exp);
          end else begin
            $display("flit %0d msvc=%0d seq_source=%h producer=%h payload=%h",
                     flits_seen, flit_o.msvc, flit_o.seq_source, flit_o.producer, flit_o.payload);
          end
        end
      end else if (req_o === 1'b1 && prev_req) begin
        total++;
        if (flit_o !== prev_flit) begin
          bad++;
          $display("FAIL flit_stable got=%h want=%h", flit_o, prev_flit);
        end
      end
      prev_req  = req_o;
      prev_flit = flit_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < BRLITE_MON_NSVC; i++) seq_model[i] = '0;
  endtask

  // Called at a negedge, returns at a negedge one cycle after the accept.
  task automatic push(input mon_msvc_t msvc, input logic [15:0] prod, input logic [31:0] pay);
    int          waited;
    brlite_mon_t e;
    waited = 0;
    while (mon_if.mon_ready !== 1'b1 && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (mon_if.mon_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL push_ready_timeout got=%b want=1", mon_if.mon_ready);
      return;
    end
    mon_if.mon_valid    = 1'b1;
    mon_if.mon_msvc     = msvc;
    mon_if.mon_producer = prod;
    mon_if.mon_payload  = pay;
    e.payload    = pay;
    e.seq_source = {seq_model[msvc], ADDR};
    e.producer   = prod;
    e.msvc       = msvc;
    exp_q.push_back(e);
    seq_model[msvc] = seq_model[msvc] + 8'd1;
    $display("push msvc=%0d seq=%0d producer=%h payload=%h", msvc, e.seq_source[15:8], prod, pay);
    @(negedge clk_i);
    mon_if.mon_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_o !== 1'b0 || ack_i !== 1'b0) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    cycles(4);
    total++;
    if (exp_q.size() != 0 || req_o !== 1'b0) begin
      bad++;
      $display("FAIL drain_%s got=pending%0d_req%b want=pending0_req0", name, exp_q.size(), req_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    mon_if.mon_valid = 1'b0;
    mon_if.mon_msvc = '0;
    mon_if.mon_producer = '0;
    mon_if.mon_payload = '0;
    model_clear();
    cycles(3);
    total += 4;
    if (req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", req_o); end
    if (mon_if.mon_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", mon_if.mon_ready); end
    if (flit_o !== '0) begin bad++; $display("FAIL reset_flit got=%h want=0", flit_o); end
    if (drop_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_drop got=%h want=0", drop_cnt_o); end
    rst_ni = 1'b1;
    cycles(2);
    total++;
    if (req_o !== 1'b0) begin bad++; $display("FAIL reset_idle_req got=%b want=0", req_o); end
    $display("reset done");
  endtask

  task automatic test_basic();
    brlite_mon_t want;
    ack_hold = 1'b0;
    push(2'd1, 16'h0102, 32'hDEADBEEF);
    total++;
    if (req_o !== 1'b0) begin bad++; $display("FAIL basic_req_early got=%b want=0", req_o); end
    cycles(1);
    want = {32'hDEADBEEF, 16'h0021, 16'h0102, 2'd1};
    total += 2;
    if (req_o !== 1'b1) begin bad++; $display("FAIL basic_req_rise got=%b want=1", req_o); end
    if (flit_o !== want) begin bad++; $display("FAIL basic_flit got=%h want=%h", flit_o, want); end
    wait_drain("basic1");
    push(2'd1, 16'h0304, 32'hCAFEF00D);
    cycles(1);
    total++;
    if (req_o !== 1'b1 || flit_o.seq_source !== 16'h0121) begin
      bad++;
      $display("FAIL basic_seq2 got=%b/%h want=1/0121", req_o, flit_o.seq_source);
    end
    wait_drain("basic2");
  endtask

  task automatic test_backpressure();
    int start;
    ack_hold = 1'b1;
    cycles(1);
    start = flits_seen;
    for (int i = 0; i < 5; i++) push(2'd0, 16'h0A00 + 16'(i), 32'h1000_0000 + i);
    total += 3;
    if (mon_if.mon_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", mon_if.mon_ready); end
    if (req_o !== 1'b1) begin bad++; $display("FAIL bp_req got=%b want=1", req_o); end
    if (flits_seen - start != 1) begin bad++; $display("FAIL bp_inflight got=%0d want=1", flits_seen - start); end
    // Refused sample: held valid while not ready, must never be delivered.
    mon_if.mon_valid   = 1'b1;
    mon_if.mon_payload = 32'hBAD0BAD0;
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      total++;
      if (mon_if.mon_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b want=0", mon_if.mon_ready); end
    end
    mon_if.mon_valid = 1'b0;
    ack_hold = 1'b0;
    wait_drain("bp");
    total++;
    if (flits_seen - start != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", flits_seen - start); end
  endtask

  task automatic test_drop();
    int start;
    ack_hold = 1'b1;
    cycles(1);
    start = flits_seen;
    total++;
    if (drop_cnt_o !== 16'h0) begin bad++; $display("FAIL drop_start got=%h want=0", drop_cnt_o); end
    for (int i = 0; i < 7; i++) push(2'd0, 16'h0B00 + 16'(i), 32'h2000_0000 + i);
    // seq 1 and 2 were the oldest queued entries and get overwritten.
    exp_q.delete(0);
    exp_q.delete(0);
    total += 3;
    if (drop_cnt_o !== 16'd2) begin bad++; $display("FAIL drop_cnt got=%0d want=2", drop_cnt_o); end
    if (mon_if.mon_ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b want=1", mon_if.mon_ready); end
    if (req_o !== 1'b1) begin bad++; $display("FAIL drop_req got=%b want=1", req_o); end
    ack_hold = 1'b0;
    wait_drain("drop");
    total++;
    if (flits_seen - start != 5) begin bad++; $display("FAIL drop_count got=%0d want=5", flits_seen - start); end
  endtask

  task automatic test_seq_wrap();
    ack_hold = 1'b0;
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    model_clear();
    for (int i = 0; i < 256; i++) begin
      push(2'd3, 16'h0300, 32'(i));
      cycles(1);
      if (i == 255) begin
        total++;
        if (req_o !== 1'b1 || flit_o.seq_source !== 16'hFF21) begin
          bad++;
          $display("FAIL wrap_seq255 got=%b/%h want=1/FF21", req_o, flit_o.seq_source);
        end
      end
      cycles(2);
    end
    push(2'd3, 16'h0301, 32'h3000_0000);
    cycles(1);
    total++;
    if (req_o !== 1'b1 || flit_o.seq_source !== 16'h0021) begin
      bad++;
      $display("FAIL wrap_seq0 got=%b/%h want=1/0021", req_o, flit_o.seq_source);
    end
    cycles(2);
    for (int s = 0; s < 3; s++) begin
      push(mon_msvc_t'(s), 16'h0400, 32'h4000_0000 + s);
      cycles(1);
      total++;
      if (req_o !== 1'b1 || flit_o.seq_source !== 16'h0021) begin
        bad++;
        $display("FAIL wrap_other%0d got=%b/%h want=1/0021", s, req_o, flit_o.seq_source);
      end
      cycles(2);
    end
    wait_drain("wrap");
    total++;
    if (drop_cnt_o !== 16'h0) begin bad++; $display("FAIL wrap_drop got=%h want=0", drop_cnt_o); end
  endtask

  task automatic test_clear();
    int start;
    ack_hold = 1'b1;
    cycles(1);
    start = flits_seen;
    for (int i = 0; i < 4; i++) push(2'd2, 16'h0C00 + 16'(i), 32'h5000_0000 + i);
    total++;
    if (req_o !== 1'b1) begin bad++; $display("FAIL clear_req_before got=%b want=1", req_o); end
    // Clear together with an accepted sample: the sample is discarded.
    mon_if.mon_valid    = 1'b1;
    mon_if.mon_msvc     = 2'd2;
    mon_if.mon_producer = 16'h0CFF;
    mon_if.mon_payload  = 32'h5555_AAAA;
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    mon_if.mon_valid = 1'b0;
    model_clear();
    cycles(1);
    total += 3;
    if (req_o !== 1'b1) begin bad++; $display("FAIL clear_inflight got=%b want=1", req_o); end
    if (mon_if.mon_ready !== 1'b1) begin bad++; $display("FAIL clear_ready got=%b want=1", mon_if.mon_ready); end
    if (drop_cnt_o !== 16'h0) begin bad++; $display("FAIL clear_drop got=%h want=0", drop_cnt_o); end
    ack_hold = 1'b0;
    wait_drain("clear");
    total++;
    if (flits_seen - start != 1) begin bad++; $display("FAIL clear_count got=%0d want=1", flits_seen - start); end
    push(2'd2, 16'h0D00, 32'h6000_0000);
    cycles(1);
    total++;
    if (req_o !== 1'b1 || flit_o.seq_source !== 16'h0021) begin
      bad++;
      $display("FAIL clear_seq0 got=%b/%h want=1/0021", req_o, flit_o.seq_source);
    end
    wait_drain("clear2");
  endtask

  task automatic test_reset_mid_send();
    int start;
    ack_hold = 1'b1;
    cycles(1);
    for (int i = 0; i < 3; i++) push(2'd1, 16'h0E00 + 16'(i), 32'h7000_0000 + i);
    total++;
    if (req_o !== 1'b1) begin bad++; $display("FAIL rstmid_req_before got=%b want=1", req_o); end
    rst_ni = 1'b0;
    cycles(1);
    total += 2;
    if (req_o !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%b want=0", req_o); end
    if (mon_if.mon_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", mon_if.mon_ready); end
    rst_ni = 1'b1;
    model_clear();
    start = flits_seen;
    cycles(3);
    total++;
    if (req_o !== 1'b0 || flits_seen != start) begin
      bad++;
      $display("FAIL rstmid_empty got=req%b_flits%0d want=req0_flits0", req_o, flits_seen - start);
    end
    ack_hold = 1'b0;
    push(2'd1, 16'h0F00, 32'h8000_0000);
    cycles(1);
    total++;
    if (req_o !== 1'b1 || flit_o.seq_source !== 16'h0021) begin
      bad++;
      $display("FAIL rstmid_seq0 got=%b/%h want=1/0021", req_o, flit_o.seq_source);
    end
    wait_drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef BRLITE_MON_TX_DROP_EN
    test_drop();
`else
    test_backpressure();
`endif
    test_seq_wrap();
    test_clear();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brlite_mon_tx.md
Name: brlite_mon_tx

Overview:
- Transmit end of the BrLite monitor path.
- Accepts local monitor samples from the PE/DMNI side and stamps each with a per-service sequence number and the local source address.
- Buffers stamped samples as brlite_mon_t entries and injects them one at a time into the BrLite monitor router over a req/ack handshake.
- The remote DMNI monitor receiver consumes these entries and writes them to the DMNI_BR_MON_PTR_* tables.

Parameters:
- ADDRESS, 8'h00: local router address, {x[3:0], y[3:0]}; fills seq_source[7:0].
- BUFFER_SIZE, 4: FIFO depth in entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- clear_i  in  1  one-cycle pulse; flushes queued entries and sequence counters.
- mon_valid_i  in  1  local sample valid.
- mon_ready_o  out  1  sample accepted when valid and ready are both high.
- mon_msvc_i  in  $clog2(BRLITE_MON_NSVC)  monitor service index.
- mon_producer_i  in  16  producer id.
- mon_payload_i  in  32  sample value.
- req_o  out  1  flit request to BrLite router.
- ack_i  in  1  router acknowledge.
- flit_o  out  $bits(brlite_mon_t)  outgoing entry; stable while req_o is high.
- drop_cnt_o  out  16  dropped-sample count; constant 0 without BRLITE_MON_TX_DROP_EN.

Behaviour:
- Reset values: all outputs 0 except mon_ready_o=1. FIFO empty, all sequence counters 0, FSM in IDLE.
- Reset mid-handshake abandons the flit; req_o is 0 in the first cycle after reset.
- Accept: on mon_valid_i && mon_ready_o, push {payload, seq_source={seq[msvc], ADDRESS}, producer, msvc} into the FIFO, then increment seq[msvc] (8 bits, wraps 255->0).
- One BRLITE_MON_NSVC-entry array of 8-bit sequence counters, indexed by msvc.
- mon_ready_o = !full, registered-state only; no combinational path from ack_i.
- Push and pop in the same cycle are both performed, and occupancy is unchanged.
- Output FSM:
  - IDLE: if FIFO not empty, load head into a flit_o register, pop it, go to SEND. Result: req_o rises 1 cycle after the first push into an empty FIFO.
  - SEND: req_o=1, flit_o held. When ack_i=1, drop req_o next cycle and go to RELEASE.
  - RELEASE: wait for ack_i=0 (4-phase handshake), then go to IDLE.
  - Back-to-back throughput is one flit per 3 cycles when ack_i returns within 1 cycle.
- An ack_i seen in IDLE or RELEASE while it is already low/ignored is not treated as a new transfer.
- clear_i:
  - Empties the FIFO and zeroes all sequence counters next cycle.
  - A flit in SEND/RELEASE completes normally.
  - If clear_i coincides with an accepted sample, the sample is discarded and the counters end at 0.
- Without the drop feature, a full FIFO holds mon_ready_o=0 until a pop.

Optional Feature:
- Macro: BRLITE_MON_TX_DROP_EN.
- Enabled:
  - mon_ready_o is tied to 1.
  - A push into a full FIFO overwrites the oldest entry: the head advances and the tail writes.
  - drop_cnt_o increments, saturating at 16'hFFFF; clear_i zeroes it.
  - The sequence number is still consumed for the new sample.
- Disabled: backpressure as described in Behaviour; drop_cnt_o tied to 0.

Decomposition:
- Add to DMNIPkg:
  - BRLITE_MON_SEQ_WIDTH = 8.
  - BRLITE_MON_ADDR_WIDTH = 8.
  - typedef enum {MON_TX_IDLE, MON_TX_SEND, MON_TX_RELEASE}.
- Reuse brlite_mon_t and BRLITE_MON_NSVC from DMNIPkg.
- One sub-module, brlite_mon_fifo:
  - Generic brlite_mon_t FIFO with push/pop/flush/full/empty ports.
  - Optional overwrite-on-full input, driven under the macro.

Test Plan:
- Reset, then push msvc=1, producer=16'h0102, payload=32'hDEADBEEF with ADDRESS=8'h21, ack_i responds 1 cycle after req -> req_o rises 1 cycle after push; flit_o={DEADBEEF, 16'h0021, 0102, 1}; second msvc=1 push yields seq_source=16'h0121.
- Push 5 samples with ack_i held 0 and BUFFER_SIZE=4, drop disabled -> after 1 sample is loaded into flit_o and 4 are queued, mon_ready_o=0; releasing ack drains all 5 in order, seq 0..4.
- Same as above with BRLITE_MON_TX_DROP_EN and 7 pushes -> the oldest queued samples are overwritten; drop_cnt_o=2; the delivered sequence skips the overwritten seq values.
- 256 pushes on msvc=3 -> seq_source[15:8] wraps 255->0; other msvc counters stay 0.
- clear_i asserted while req_o=1 with 3 queued -> the in-flight flit completes, the queue empties, and the next push carries seq 0.
- rst_ni low while in SEND -> req_o=0 next cycle; FIFO empty; mon_ready_o=1.
